// File: rtl/mdsa_pkg.sv
// Shared definitions for the multidimensional sort slice: loader state encoding,
// default geometry and the phase delay used by the sort controller.
package mdsa_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_ARM    = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_SORT   = 2'd3
  } loader_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DELAY      = 8;

endpackage

// File: rtl/mdsa_matrix_buf.sv
// N-word write-addressed register file with a flat, row-major read-out bus.
module mdsa_matrix_buf #(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_data,
  output logic [N*DATA_W-1:0]   o_flat
);

  logic [N*DATA_W-1:0] r_flat;

  // Address decode by comparison keeps the index width independent of N.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flat <= '0;
    end else if (i_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_addr == ADDR_W'(i)) r_flat[i*DATA_W +: DATA_W] <= i_data;
      end
    end
  end

  assign o_flat = r_flat;

endmodule

// File: rtl/mdsa_input_loader.sv
// Serial-to-matrix loader: fills ROWS*COLS elements, launches the sort controller
// through START/READY, holds the matrix frozen until the completion pulse.
module mdsa_input_loader
  import mdsa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  input  logic                              fsm_ready,
  input  logic                              fsm_done,
  output logic                              start,
  output logic [ROWS*COLS*DATA_W-1:0]       matrix,
  output logic [$clog2(ROWS*COLS+1)-1:0]    fill_count,
  output logic                              busy
);

  localparam int N     = ROWS * COLS;
  localparam int PTR_W = $clog2(N + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] FULL_IDX = PTR_W'(N);

  loader_state_e    r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic             w_we;

  assign w_we = in_valid && (r_state == ST_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_wr_ptr <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            if (r_wr_ptr == LAST_IDX) begin
              r_wr_ptr <= FULL_IDX;
              r_state  <= ST_ARM;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end
        end
        ST_ARM:    if (fsm_ready)  r_state <= ST_LAUNCH;
        // START stays up until the controller leaves its WAIT state.
        ST_LAUNCH: if (!fsm_ready) r_state <= ST_SORT;
        ST_SORT: begin
          if (fsm_done) begin
            r_state  <= ST_FILL;
            r_wr_ptr <= '0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_FILL);
  assign start      = (r_state == ST_LAUNCH);
  assign busy       = (r_state != ST_FILL);
  assign fill_count = r_wr_ptr;

  mdsa_matrix_buf #(
    .DATA_W (DATA_W),
    .N      (N),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_addr (r_wr_ptr),
    .i_data (in_data),
    .o_flat (matrix)
  );

endmodule

// File: tb/tb_mdsa_input_loader.sv
// Directed bench for mdsa_input_loader: fill, launch, sort freeze, refill and resets.
module tb_mdsa_input_loader;

  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int N      = ROWS * COLS;
  localparam int PTR_W  = $clog2(N + 1);
  localparam int MW     = N * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fsm_ready;
  logic              fsm_done;
  logic              start;
  logic [MW-1:0]     matrix;
  logic [PTR_W-1:0]  fill_count;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;
  logic [MW-1:0] exp_mat;

  mdsa_input_loader #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fsm_ready  (fsm_ready),
    .fsm_done   (fsm_done),
    .start      (start),
    .matrix     (matrix),
    .fill_count (fill_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic e_rdy, input logic e_start,
                          input logic e_busy, input int e_cnt);
    chk({tag, ".in_ready"}, MW'(in_ready), MW'(e_rdy));
    chk({tag, ".start"}, MW'(start), MW'(e_start));
    chk({tag, ".busy"}, MW'(busy), MW'(e_busy));
    chk({tag, ".fill_count"}, MW'(fill_count), MW'(e_cnt));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; fsm_ready = 1'b0; fsm_done = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 0);
    chk("reset.matrix", matrix, '0);

    // Back-to-back fill 0x0F..0x00 with the controller already ready
    fsm_ready = 1'b1;
    exp_mat = '0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(15 - i);
      exp_mat[i*DATA_W +: DATA_W] = DATA_W'(15 - i);
      step();
      if (i < N - 1) chk("b2b.count", MW'(fill_count), MW'(i + 1));
    end
    in_valid = 1'b0;
    chk_ctrl("arm", 1'b0, 1'b0, 1'b1, 16);
    chk("b2b.first", MW'(matrix[7:0]), MW'(8'h0F));
    chk("b2b.last", MW'(matrix[127:120]), MW'(8'h00));
    step();
    chk_ctrl("launch", 1'b0, 1'b1, 1'b1, 16);

    // Controller leaves WAIT; input kept active with 0x55 to prove the freeze
    in_valid = 1'b1; in_data = 8'h55;
    step();
    chk("launch.hold", MW'(start), MW'(1'b1));
    fsm_ready = 1'b0;
    step();
    chk_ctrl("sort", 1'b0, 1'b0, 1'b1, 16);
    step(); step();
    chk("sort.frozen", matrix, exp_mat);
    fsm_ready = 1'b1;
    fsm_done  = 1'b1;
    step();
    fsm_done = 1'b0; fsm_ready = 1'b0;
    chk_ctrl("done", 1'b1, 1'b0, 1'b0, 0);
    chk("done.kept", matrix, exp_mat);

    in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    exp_mat[7:0] = 8'hAA;
    chk("refill.w0", MW'(matrix[7:0]), MW'(8'hAA));
    chk("refill.w1old", MW'(matrix[15:8]), MW'(8'h0E));
    chk("refill.count", MW'(fill_count), MW'(1));

    // Stale completion pulse during FILL
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
    chk_ctrl("stale.fill", 1'b1, 1'b0, 1'b0, 1);

    // Gapped stream for words 1..15, junk on the idle cycles
    for (int j = 0; j < 30; j++) begin
      if (j % 2 == 0) begin
        in_valid = 1'b1;
        in_data  = DATA_W'(8'h30 + j / 2 + 1);
        exp_mat[(j/2+1)*DATA_W +: DATA_W] = DATA_W'(8'h30 + j / 2 + 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
      end
      step();
      if (j < 29) chk("gap.count", MW'(fill_count), MW'(j / 2 + 2));
    end
    chk("gap.matrix", matrix, exp_mat);

    // ARM while the controller is not ready, with input and stale done active
    in_valid = 1'b1; in_data = 8'h55;
    for (int j = 0; j < 20; j++) begin
      fsm_done = (j == 5);
      step();
    end
    fsm_done = 1'b0;
    chk_ctrl("arm.wait", 1'b0, 1'b0, 1'b1, 16);
    fsm_ready = 1'b1;
    step();
    chk("arm.launch", MW'(start), MW'(1'b1));
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
    chk("launch.stale", MW'(start), MW'(1'b1));
    fsm_ready = 1'b0;
    step();
    chk_ctrl("sort2", 1'b0, 1'b0, 1'b1, 16);
    chk("sort2.frozen", matrix, exp_mat);

    // Done and ready together: done wins
    fsm_done = 1'b1; fsm_ready = 1'b1; in_valid = 1'b0;
    step();
    fsm_done = 1'b0; fsm_ready = 1'b0;
    chk_ctrl("prio", 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-fill after 9 words
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(8'hC0 + i);
      step();
    end
    in_valid = 1'b0;
    chk("mid.count", MW'(fill_count), MW'(9));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_ctrl("rst.fill", 1'b1, 1'b0, 1'b0, 0);
    chk("rst.fill.matrix", matrix, '0);

    // Reset while launching
    fsm_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(8'h80 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("pre.launch", MW'(start), MW'(1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0; fsm_ready = 1'b0;
    chk_ctrl("rst.launch", 1'b1, 1'b0, 1'b0, 0);
    chk("rst.launch.matrix", matrix, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
